// File: rtl/rd53_cmd_scheduler.sv
// RD53A command-frame scheduler: picks one 16-bit frame per serializer slot from
// mandatory syncs, buffered triggers, multi-frame cfg commands, or NOOP fill.
module rd53_cmd_scheduler #(
    parameter int unsigned SYNC_PERIOD = 32,
    parameter int unsigned INIT_SYNCS  = 64,
    parameter int unsigned TRIG_DEPTH  = 4,
    parameter logic [15:0] SYNC_WORD   = 16'h817E,
    parameter logic [15:0] NOOP_WORD   = 16'h6969
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_strobe,
    input  logic        trig_valid,
    input  logic [15:0] trig_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [15:0] cfg_data,
    input  logic        cfg_last,
    output logic [15:0] frame_data,
    output logic        init_done,
    output logic        trig_drop,
    output logic        cfg_underrun
);
    localparam int unsigned AW        = $clog2(TRIG_DEPTH);
    localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);
    localparam logic [7:0]  INIT_LAST = 8'(INIT_SYNCS - 1);
    localparam logic [7:0]  SYNC_LAST = 8'(SYNC_PERIOD - 1);

    typedef enum logic {TOP_INIT, TOP_RUN} top_state_t;
    typedef enum logic {CFG_IDLE, CFG_BUSY} cfg_state_t;

    top_state_t  top_state, top_next;
    cfg_state_t  cfg_state, cfg_next;
    logic [7:0]  init_cnt, init_cnt_next;
    logic [7:0]  sync_cnt, sync_cnt_next;
    logic [15:0] frame_next;
    logic        underrun_next;
    logic        sync_due;

    logic [15:0] trig_mem [TRIG_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, trig_push, trig_pop;

    // Pointers carry one extra MSB so a full FIFO is distinguishable from an empty one.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign sync_due   = (sync_cnt == SYNC_LAST);
    assign trig_push  = trig_valid && (!fifo_full || trig_pop);
    assign init_done  = (top_state == TOP_RUN);

    always_comb begin
        top_next      = top_state;
        cfg_next      = cfg_state;
        init_cnt_next = init_cnt;
        sync_cnt_next = sync_cnt;
        frame_next    = frame_data;
        trig_pop      = 1'b0;
        cfg_ready     = 1'b0;
        underrun_next = 1'b0;
        if (frame_strobe) begin
            case (top_state)
                TOP_INIT: begin
                    frame_next    = SYNC_WORD;
                    init_cnt_next = init_cnt + 8'd1;
                    if (init_cnt == INIT_LAST) top_next = TOP_RUN;
                end
                TOP_RUN: begin
                    if (sync_due) begin
                        frame_next    = SYNC_WORD;
                        sync_cnt_next = '0;
                    end else begin
                        sync_cnt_next = sync_cnt + 8'd1;
                        if (!fifo_empty) begin
                            frame_next = trig_mem[rd_ptr[AW-1:0]];
                            trig_pop   = 1'b1;
                        end else if (cfg_valid) begin
                            frame_next = cfg_data;
                            cfg_ready  = 1'b1;
                            cfg_next   = cfg_last ? CFG_IDLE : CFG_BUSY;
                        end else begin
                            // Filling a gap inside an open cfg command is flagged upstream.
                            frame_next    = NOOP_WORD;
                            underrun_next = (cfg_state == CFG_BUSY);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_state    <= TOP_INIT;
            cfg_state    <= CFG_IDLE;
            init_cnt     <= '0;
            sync_cnt     <= '0;
            frame_data   <= SYNC_WORD;
            trig_drop    <= 1'b0;
            cfg_underrun <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            top_state    <= top_next;
            cfg_state    <= cfg_next;
            init_cnt     <= init_cnt_next;
            sync_cnt     <= sync_cnt_next;
            frame_data   <= frame_next;
            trig_drop    <= trig_valid && fifo_full && !trig_pop;
            cfg_underrun <= underrun_next;
            if (trig_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (trig_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage array has no reset; pointer reset alone makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (trig_push) trig_mem[wr_ptr[AW-1:0]] <= trig_data;
    end

endmodule

// File: tb/tb_rd53_cmd_scheduler.sv
// Self-checking bench for rd53_cmd_scheduler: directed sequences, a vector table,
// and randomized traffic compared against a queue-based behavioural model.
module tb_rd53_cmd_scheduler;
    localparam int          SYNC_PERIOD = 32;
    localparam int          INIT_SYNCS  = 64;
    localparam int          TRIG_DEPTH  = 4;
    localparam logic [15:0] SYNC        = 16'h817E;
    localparam logic [15:0] NOOP        = 16'h6969;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_strobe = 1'b0;
    logic        trig_valid = 1'b0;
    logic [15:0] trig_data = '0;
    logic        cfg_valid, cfg_last;
    logic        cfg_ready;
    logic [15:0] cfg_data;
    logic [15:0] frame_data;
    logic        init_done, trig_drop, cfg_underrun;

    rd53_cmd_scheduler #(
        .SYNC_PERIOD(SYNC_PERIOD), .INIT_SYNCS(INIT_SYNCS), .TRIG_DEPTH(TRIG_DEPTH),
        .SYNC_WORD(SYNC), .NOOP_WORD(NOOP)
    ) dut (
        .clk(clk), .rst(rst), .frame_strobe(frame_strobe),
        .trig_valid(trig_valid), .trig_data(trig_data),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .frame_data(frame_data), .init_done(init_done),
        .trig_drop(trig_drop), .cfg_underrun(cfg_underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } cfg_t;

    cfg_t cfg_q[$];
    bit   cfg_hold = 1'b0;
    int   ready_seen = 0;

    // Behavioural model state
    int          m_init, m_sync;
    bit          m_run, m_busy, m_drop, m_under;
    logic [15:0] m_frame;
    logic [15:0] m_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cfg();
        cfg_valid = (cfg_q.size() > 0) && !cfg_hold;
        cfg_data  = (cfg_q.size() > 0) ? cfg_q[0].data : 16'h0;
        cfg_last  = (cfg_q.size() > 0) ? cfg_q[0].last : 1'b0;
    endtask

    task automatic model_reset();
        m_init = 0; m_sync = 0; m_run = 0; m_busy = 0;
        m_drop = 0; m_under = 0; m_frame = SYNC;
        m_q.delete();
    endtask

    task automatic model_step(input logic s, input logic tv, input logic [15:0] td,
                              input logic cv, input logic [15:0] cd, input logic cl,
                              output logic ready);
        ready   = 1'b0;
        m_drop  = 0;
        m_under = 0;
        if (s) begin
            if (!m_run) begin
                m_frame = SYNC;
                m_init++;
                if (m_init == INIT_SYNCS) m_run = 1;
            end else if (m_sync == SYNC_PERIOD - 1) begin
                m_frame = SYNC;
                m_sync  = 0;
            end else begin
                m_sync++;
                if (m_q.size() > 0) begin
                    m_frame = m_q.pop_front();
                end else if (cv) begin
                    m_frame = cd;
                    ready   = 1'b1;
                    m_busy  = !cl;
                end else begin
                    m_frame = NOOP;
                    m_under = m_busy;
                end
            end
        end
        // A pop in this slot frees space for a same-cycle push.
        if (tv) begin
            if (m_q.size() < TRIG_DEPTH) m_q.push_back(td);
            else m_drop = 1;
        end
    endtask

    // Called and returning at posedge+1.
    task automatic cycle(input logic s, input logic tv, input logic [15:0] td);
        logic exp_ready;
        frame_strobe = s;
        trig_valid   = tv;
        trig_data    = td;
        drive_cfg();
        #3;
        model_step(s, tv, td, cfg_valid, cfg_data, cfg_last, exp_ready);
        check("cfg_ready", 16'(cfg_ready), 16'(exp_ready));
        if (cfg_ready) ready_seen++;
        if (exp_ready) cfg_q.delete(0);
        @(posedge clk);
        #1;
        check("frame_data", frame_data, m_frame);
        check("init_done", 16'(init_done), 16'(m_run));
        check("trig_drop", 16'(trig_drop), 16'(m_drop));
        check("cfg_underrun", 16'(cfg_underrun), 16'(m_under));
    endtask

    task automatic slot(input int gap, output logic [15:0] f);
        cycle(1'b1, 1'b0, 16'h0);
        f = frame_data;
        for (int i = 1; i < gap; i++) cycle(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_strobe = 1'b0;
        trig_valid = 1'b0;
        cfg_q.delete();
        cfg_hold = 1'b0;
        drive_cfg();
        #1;
        check("rst_frame", frame_data, SYNC);
        check("rst_init_done", 16'(init_done), 16'h0);
        check("rst_trig_drop", 16'(trig_drop), 16'h0);
        check("rst_underrun", 16'(cfg_underrun), 16'h0);
        check("rst_cfg_ready", 16'(cfg_ready), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_init(input int gap);
        logic [15:0] f;
        for (int i = 0; i < INIT_SYNCS; i++) slot(gap, f);
    endtask

    typedef struct {
        logic        s;
        logic        tv;
        logic [15:0] td;
        logic [15:0] exp_frame;
        logic        exp_drop;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f, f1, f2, f3, f4;

        tbl[0]  = '{1'b0, 1'b1, 16'hA001, SYNC,     1'b0};
        tbl[1]  = '{1'b0, 1'b1, 16'hA002, SYNC,     1'b0};
        tbl[2]  = '{1'b0, 1'b1, 16'hA003, SYNC,     1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'hA004, SYNC,     1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'hA005, SYNC,     1'b1};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 16'hA001, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 16'hA001, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 16'hA002, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 16'hA003, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 16'hA004, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, NOOP,     1'b0};

        drive_cfg();
        @(posedge clk);
        #1;

        // T1: INIT syncs at one slot per 16 clocks, then 31 NOOPs + 1 sync repeating
        do_reset();
        for (int i = 0; i < INIT_SYNCS; i++) begin
            slot(16, f);
            check("t1_init_sync", f, SYNC);
            if (i == INIT_SYNCS - 2) check("t1_init_done_early", 16'(init_done), 16'h0);
        end
        check("t1_init_done", 16'(init_done), 16'h1);
        for (int k = 0; k < 2 * SYNC_PERIOD; k++) begin
            slot(16, f);
            check("t1_run_slot", f, (k % SYNC_PERIOD == SYNC_PERIOD - 1) ? SYNC : NOOP);
        end

        // T2: trigger interleaved into a 3-frame cfg command
        do_reset();
        run_init(2);
        cfg_q.push_back('{16'hA1A1, 1'b0});
        cfg_q.push_back('{16'hA2A2, 1'b0});
        cfg_q.push_back('{16'hA3A3, 1'b1});
        ready_seen = 0;
        cycle(1'b1, 1'b0, 16'h0);
        f1 = frame_data;
        cycle(1'b0, 1'b1, 16'h7777);
        slot(2, f2);
        slot(2, f3);
        slot(2, f4);
        check("t2_slot_a1", f1, 16'hA1A1);
        check("t2_slot_trig", f2, 16'h7777);
        check("t2_slot_a2", f3, 16'hA2A2);
        check("t2_slot_a3", f4, 16'hA3A3);
        check("t2_ready_cycles", 16'(ready_seen), 16'd3);

        // T3: overfill the trigger FIFO with no strobes, then drain (vector table)
        do_reset();
        run_init(2);
        for (int i = 0; i < $size(tbl); i++) begin
            cycle(tbl[i].s, tbl[i].tv, tbl[i].td);
            check("t3_frame", frame_data, tbl[i].exp_frame);
            check("t3_drop", 16'(trig_drop), 16'(tbl[i].exp_drop));
        end

        // T4: cfg_valid drops inside an open command
        do_reset();
        run_init(2);
        cfg_q.push_back('{16'hB1B1, 1'b0});
        cfg_q.push_back('{16'hB2B2, 1'b1});
        slot(2, f);
        check("t4_b1", f, 16'hB1B1);
        cfg_hold = 1'b1;
        cycle(1'b1, 1'b0, 16'h0);
        check("t4_noop", frame_data, NOOP);
        check("t4_underrun", 16'(cfg_underrun), 16'h1);
        cycle(1'b0, 1'b0, 16'h0);
        check("t4_underrun_pulse", 16'(cfg_underrun), 16'h0);
        cfg_hold = 1'b0;
        slot(2, f);
        check("t4_b2", f, 16'hB2B2);
        cycle(1'b1, 1'b0, 16'h0);
        check("t4_idle_noop_no_underrun", 16'(cfg_underrun), 16'h0);

        // T5: sync due while a trigger and a cfg frame are both pending
        do_reset();
        run_init(2);
        for (int i = 0; i < SYNC_PERIOD - 1; i++) slot(2, f);
        cfg_q.push_back('{16'hC1C1, 1'b1});
        cycle(1'b0, 1'b1, 16'h5555);
        slot(2, f1);
        slot(2, f2);
        slot(2, f3);
        check("t5_sync_first", f1, SYNC);
        check("t5_trig_second", f2, 16'h5555);
        check("t5_cfg_third", f3, 16'hC1C1);

        // T6: reset in CFG_BUSY with two triggers queued
        do_reset();
        run_init(2);
        cfg_q.push_back('{16'hD1D1, 1'b0});
        cfg_q.push_back('{16'hD2D2, 1'b1});
        slot(2, f);
        cycle(1'b0, 1'b1, 16'hE001);
        cycle(1'b0, 1'b1, 16'hE002);
        do_reset();
        for (int i = 0; i < INIT_SYNCS; i++) begin
            slot(2, f);
            check("t6_resync", f, SYNC);
        end
        cycle(1'b1, 1'b0, 16'h0);
        check("t6_fifo_flushed", frame_data, NOOP);
        check("t6_cfg_idle", 16'(cfg_underrun), 16'h0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            logic s, tv;
            if (cfg_q.size() == 0 && $urandom_range(0, 19) == 0) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++)
                    cfg_q.push_back('{16'($urandom), (j == len - 1)});
            end
            cfg_hold = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 2) == 0);
            tv = ($urandom_range(0, 3) == 0);
            cycle(s, tv, 16'($urandom));
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
